vedic_mult_pipe: RTL and testbench
==================================

Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier; next generation of the 2x2 Vedic block.
- Generalises the operand width to any power of two ≥ 2 by recursively splitting each operand into four half-width partial products.
- Adds register stages and a valid/ready handshake on both sides, so it can sit in a streaming datapath with backpressure.

Parameters:
- WIDTH, 8, operand width in bits; power of two, 2..32; product width is 2*WIDTH.
- OUT_REG, 1, 1 = registered output stage (latency 3); 0 = combinational final adder feeding the output (latency 2).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair a/b is valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  p holds a valid product.
- out_ready  input  1  downstream accepts p this cycle.
- p  output  2*WIDTH  product a*b.
- occupancy  output  2  number of operations currently in flight (0..LAT).

Behaviour:
- Reset (rst_n=0, async): all stage valid bits = 0, out_valid=0, p=0, occupancy=0. in_ready is 1 while in reset and afterwards whenever the pipe can advance.
- Global advance enable: adv = ~out_valid | out_ready. in_ready = adv. All stage registers load only when adv=1; otherwise every stage holds.
- A transfer occurs on a cycle with in_valid & in_ready. Output is consumed on a cycle with out_valid & out_ready.
- Stage 1 (S1): register a, b, and the valid bit.
- Stage 2 (S2): register the four half-width products from vedic_core:
  - pp_ll = aL*bL
  - pp_lh = aL*bH
  - pp_hl = aH*bL
  - pp_hh = aH*bH
- Stage 3 (S3, present when OUT_REG=1): p = pp_ll + ((pp_lh + pp_hl) << WIDTH/2) + (pp_hh << WIDTH).
  - Middle sum is WIDTH+1 bits, so no carry is lost.
  - Final sum is exactly 2*WIDTH bits and never overflows.
- Latency: LAT = 2 + OUT_REG cycles from accept to out_valid, with no stall. Throughput is 1 op/cycle while out_ready=1.
- Bubbles (stage valid=0) advance with the pipe. They are not squeezed out while stalled; no data is dropped or duplicated.
- Stall: out_valid=1 & out_ready=0 → p, out_valid and all stage contents hold stable; in_ready=0.
- Simultaneous accept and output consume in the same cycle: both occur; occupancy is unchanged.
- occupancy: +1 on accept, −1 on consume, unchanged when both or neither occur.
- p is don't-care when out_valid=0, but must not be X after reset.
- Reset mid-operation: all in-flight ops are discarded. The first accept after reset deassertion produces the first output.
- WIDTH=2 base case: vedic_core is the 2x2 gate form:
  - p0 = a0b0
  - p1 = a1b0 ^ a0b1
  - carry c1 = a1b0 & a0b1
  - p2 = a1b1 ^ c1
  - p3 = a1b1 & c1

Optional Feature:
- Macro VEDIC_SIGNED_EN.
- Defined: adds input port op_signed (1 bit), sampled with a/b on accept and carried through the pipe with the data.
  - op_signed=1 treats a and b as two's complement: multiply magnitudes, negate p when sign(a)^sign(b).
  - The negation is applied in the final stage, and latency is unchanged.
- Undefined: the port is absent and all operands are unsigned.

Decomposition:
- Package vedic_pkg holds:
  - function vedic_lat(OUT_REG) returning LAT.
  - localparam MAX_WIDTH = 32.
  - Elaboration check that WIDTH is a power of two in 2..MAX_WIDTH.
- Sub-module vedic_core (WIDTH parameter): purely combinational NxN Vedic multiplier.
  - Recursive generate: four vedic_core #(WIDTH/2) instances plus adders.
  - Base case is the 2x2 gate form above.
  - vedic_mult_pipe instantiates four vedic_core #(WIDTH/2) instances in S2.

Test Plan:
- WIDTH=2, OUT_REG=1: 00*00, 01*01, 10*10, 11*01, 11*10, 11*11 → p = 0000, 0001, 0100, 0011, 0110, 1001. Each p appears exactly 3 cycles after accept.
- WIDTH=4: exhaustive 256 pairs, back-to-back, out_ready=1 → every p matches a*b (e.g. 15*15=225) with 1 op/cycle throughput; occupancy holds at 3 in steady state.
- WIDTH=8: issue 255*255, then hold out_ready=0 for 5 cycles → p=65025 and out_valid stay stable; in_ready=0; no loss and no duplication after release.
- WIDTH=8, random in_valid and out_ready (50%) over 10k ops → scoreboard order and values match; occupancy never exceeds 3.
- Assert rst_n=0 with 2 ops in flight → out_valid=0, occupancy=0 at once; the next op 7*9 yields p=63 with no stale outputs.
- VEDIC_SIGNED_EN, WIDTH=4, op_signed=1: −8*7 → p = 8'hC8 (−56); −8*−8 → p=64; with op_signed=0, 8*7 → p=56.

Source files
------------

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared constants and helpers for the pipelined Vedic multiplier
package vedic_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic int vedic_lat(input int out_reg);
    return 2 + out_reg;
  endfunction

  function automatic bit vedic_width_ok(input int w);
    return (w >= 2) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/vedic_core.sv
// rtl/vedic_core.sv - combinational NxN Urdhva-Tiryagbhyam multiplier, recursive on half-width cores
module vedic_core #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  if (WIDTH == 1) begin : g_bit
    // Half-width leaf used when the pipelined top itself is only 2 bits wide.
    assign p = {1'b0, a[0] & b[0]};
  end else if (WIDTH == 2) begin : g_base
    logic c1;
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_split
    localparam int H = WIDTH / 2;
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [WIDTH:0]   mid;

    vedic_core #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(pp_ll));
    vedic_core #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(pp_lh));
    vedic_core #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(pp_hl));
    vedic_core #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(pp_hh));

    assign mid = {1'b0, pp_lh} + {1'b0, pp_hl};
    assign p   = {pp_hh, pp_ll} + ({{(WIDTH-1){1'b0}}, mid} << H);
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - pipelined valid/ready Vedic multiplier; VEDIC_SIGNED_EN adds op_signed
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         occupancy
);

  localparam int H = WIDTH / 2;

  if (!vedic_width_ok(WIDTH) || (OUT_REG != 0 && OUT_REG != 1) || vedic_lat(OUT_REG) > 3) begin : g_bad_cfg
    $error("vedic_mult_pipe: unsupported WIDTH or OUT_REG");
  end

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
    end
  end

`ifdef VEDIC_SIGNED_EN
  // Signed ops multiply magnitudes; the sign travels alongside and is applied at the end.
  logic s1_sgn, s1_neg, s2_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sgn <= 1'b0;
      s2_neg <= 1'b0;
    end else if (adv) begin
      s1_sgn <= op_signed;
      s2_neg <= s1_neg;
    end
  end

  always_comb begin
    mag_a  = (s1_sgn & s1_a[WIDTH-1]) ? -s1_a : s1_a;
    mag_b  = (s1_sgn & s1_b[WIDTH-1]) ? -s1_b : s1_b;
    s1_neg = s1_sgn & (s1_a[WIDTH-1] ^ s1_b[WIDTH-1]);
  end
`else
  assign mag_a = s1_a;
  assign mag_b = s1_b;
`endif

  logic [WIDTH-1:0] c_ll, c_lh, c_hl, c_hh;

  vedic_core #(.WIDTH(H)) u_ll (.a(mag_a[H-1:0]),     .b(mag_b[H-1:0]),     .p(c_ll));
  vedic_core #(.WIDTH(H)) u_lh (.a(mag_a[H-1:0]),     .b(mag_b[WIDTH-1:H]), .p(c_lh));
  vedic_core #(.WIDTH(H)) u_hl (.a(mag_a[WIDTH-1:H]), .b(mag_b[H-1:0]),     .p(c_hl));
  vedic_core #(.WIDTH(H)) u_hh (.a(mag_a[WIDTH-1:H]), .b(mag_b[WIDTH-1:H]), .p(c_hh));

  logic             s2_valid;
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      pp_ll    <= '0;
      pp_lh    <= '0;
      pp_hl    <= '0;
      pp_hh    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      pp_ll    <= c_ll;
      pp_lh    <= c_lh;
      pp_hl    <= c_hl;
      pp_hh    <= c_hh;
    end
  end

  logic [WIDTH:0]     mid;
  logic [2*WIDTH-1:0] sum, prod;

  assign mid = {1'b0, pp_lh} + {1'b0, pp_hl};
  assign sum = {pp_hh, pp_ll} + ({{(WIDTH-1){1'b0}}, mid} << H);

`ifdef VEDIC_SIGNED_EN
  assign prod = s2_neg ? -sum : sum;
`else
  assign prod = sum;
`endif

  if (OUT_REG == 1) begin : g_out_reg
    logic               s3_valid;
    logic [2*WIDTH-1:0] s3_p;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_valid <= 1'b0;
        s3_p     <= '0;
      end else if (adv) begin
        s3_valid <= s2_valid;
        s3_p     <= prod;
      end
    end

    assign out_valid = s3_valid;
    assign p         = s3_p;
    assign occupancy = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
  end else begin : g_out_comb
    assign out_valid = s2_valid;
    assign p         = prod;
    assign occupancy = 2'(s1_valid) + 2'(s2_valid);
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - directed and randomized checks of vedic_mult_pipe (8-bit registered, 4-bit unregistered)
module tb_vedic_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 1'b0, or8 = 1'b1, ir8, ov8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic [1:0]  occ8;

  logic        iv4 = 1'b0, or4 = 1'b1, ir4, ov4, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;
  logic [1:0]  occ4;

  int checks = 0;
  int errors = 0;
  int acc8 = 0;
  int occm8 = 0, occm4 = 0;
  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];

  vedic_mult_pipe #(.WIDTH(8), .OUT_REG(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef VEDIC_SIGNED_EN
    .op_signed(1'b0),
`endif
    .out_valid(ov8), .out_ready(or8), .p(p8), .occupancy(occ8)
  );

  vedic_mult_pipe #(.WIDTH(4), .OUT_REG(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
`ifdef VEDIC_SIGNED_EN
    .op_signed(sgn4),
`endif
    .out_valid(ov4), .out_ready(or4), .p(p4), .occupancy(occ4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp4(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic signed [7:0] sx, sy;
    sx = $signed({{4{x[3]}}, x});
    sy = $signed({{4{y[3]}}, y});
    if (s) return 8'(sx * sy);
    return {4'b0, x} * {4'b0, y};
  endfunction

  // Scoreboards and occupancy models, sampled mid-cycle ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb8.delete();
      sb4.delete();
      occm8 = 0;
      occm4 = 0;
    end else begin
      chk("occ8", {30'b0, occ8}, occm8);
      if (iv8 && ir8) begin
        sb8.push_back(16'(a8) * 16'(b8));
        acc8++;
      end
      if (ov8 && or8) begin
        chk("sb8_nonempty", sb8.size() != 0, 1);
        if (sb8.size() != 0) chk("p8", p8, sb8.pop_front());
      end
      occm8 = occm8 + int'(iv8 && ir8) - int'(ov8 && or8);

      chk("occ4", {30'b0, occ4}, occm4);
      if (iv4 && ir4) sb4.push_back(exp4(a4, b4, sgn4));
      if (ov4 && or4) begin
        chk("sb4_nonempty", sb4.size() != 0, 1);
        if (sb4.size() != 0) chk("p4", p4, sb4.pop_front());
      end
      occm4 = occm4 + int'(iv4 && ir4) - int'(ov4 && or4);
    end
  end

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e, input string tag);
    int n;
    a8 = x; b8 = y; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, p8, e);
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e, input string tag);
    int n;
    a4 = x; b4 = y; iv4 = 1'b1; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 1;
    while (!ov4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 2);
    chk(tag, p4, e);
  endtask

  initial begin
    int n, start;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov8", ov8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_occ8", occ8, 0);
    chk("rst_ir8", ir8, 1);
    chk("rst_ov4", ov4, 0);
    chk("rst_p4", p4, 0);
    chk("rst_occ4", occ4, 0);
    chk("rst_ir4", ir4, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8(8'd0,   8'd0,   16'd0,     "m8_0x0");
    run8(8'd7,   8'd9,   16'd63,    "m8_7x9");
    run8(8'd255, 8'd255, 16'd65025, "m8_255x255");
    run8(8'd1,   8'd255, 16'd255,   "m8_1x255");
    run8(8'd128, 8'd2,   16'd256,   "m8_128x2");
    run8(8'd170, 8'd85,  16'd14450, "m8_170x85");
    run8(8'd15,  8'd17,  16'd255,   "m8_15x17");
    run8(8'd200, 8'd100, 16'd20000, "m8_200x100");

    run4(4'd15, 4'd15, 8'd225, "m4_15x15");
    run4(4'd0,  4'd9,  8'd0,   "m4_0x9");
    run4(4'd12, 4'd5,  8'd60,  "m4_12x5");
    run4(4'd9,  4'd9,  8'd81,  "m4_9x9");

    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4); b4 = 4'(i); iv4 = 1'b1;
      if (i == 100) chk("occ4_steady", occ4, 2);
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Stall: the product must hold while downstream refuses it.
    or8 = 1'b0; a8 = 8'd255; b8 = 8'd255; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_ov_rise", ov8, 1);
    a8 = 8'd3; b8 = 8'd3; iv8 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_p", p8, 65025);
      chk("stall_ov", ov8, 1);
      chk("stall_ir", ir8, 0);
      chk("stall_occ", occ8, 1);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("after_stall", p8, 9);
    @(posedge clk); #1;

    start = acc8;
    n = 0;
    while ((acc8 - start) < 2000 && n < 40000) begin
      iv8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      or8 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("rand_done", (acc8 - start) >= 2000, 1);
    iv8 = 1'b0; or8 = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset with two operations in flight: both must vanish.
    a8 = 8'd1; b8 = 8'd2; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd3; b8 = 8'd4;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("pre_rst_occ", occ8, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", ov8, 0);
    chk("midrst_occ", occ8, 0);
    chk("midrst_p", p8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'd7, 8'd9, 16'd63, "post_rst_7x9");

`ifdef VEDIC_SIGNED_EN
    sgn4 = 1'b1;
    run4(4'h8, 4'h7, 8'hC8, "s4_m8x7");
    run4(4'h8, 4'h8, 8'd64, "s4_m8xm8");
    run4(4'hF, 4'h3, 8'hFD, "s4_m1x3");
    sgn4 = 1'b0;
    run4(4'h8, 4'h7, 8'd56, "u4_8x7");
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("drain8", sb8.size(), 0);
    chk("drain4", sb4.size(), 0);
    chk("idle_occ8", occ8, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
